// File: rtl/button_step_ctrl.sv
// Up/down button stepper: synchronizes and debounces two raw buttons, then issues
// single-cycle step pulses with hold-to-auto-repeat and a both-pressed lockout.
module button_step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 64,
    parameter int REPEAT_CYCLES   = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_up,
    input  logic btn_down,
    output logic step,
    output logic up_down,
    output logic busy
);

    // state  | meaning
    // IDLE   | no button accepted, waiting for a single press
    // HOLD   | first step issued, waiting HOLD_CYCLES before auto-repeat
    // REPEAT | auto-repeat, one step every REPEAT_CYCLES
    // LOCK   | both buttons seen, wait for both released
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HOLD   = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;
    localparam logic [1:0] ST_LOCK   = 2'd3;

    localparam int MAX_T = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int TW    = $clog2(MAX_T + 1);
    localparam int DW    = $clog2(DEBOUNCE_CYCLES + 1);

    // index 0 = up button, index 1 = down button
    logic [1:0]    sync1_q, sync2_q;
    logic [1:0]    deb_q, deb_d;
    logic [DW-1:0] db_cnt_q [2];
    logic [DW-1:0] db_cnt_d [2];

    logic [1:0]    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          step_q, step_d;
    logic          up_down_q, up_down_d;
    logic          act_btn, opp_btn;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            deb_d[i]    = deb_q[i];
            db_cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (db_cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // The held button is identified by the latched direction, so a mid-hold
    // change of which button is pressed can never flip the direction.
    assign act_btn = up_down_q ? deb_q[0] : deb_q[1];
    assign opp_btn = up_down_q ? deb_q[1] : deb_q[0];

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        step_d    = 1'b0;
        up_down_d = up_down_q;
        case (state_q)
            ST_IDLE: begin
                if (deb_q[0] && deb_q[1]) begin
                    state_d = ST_LOCK;
                end else if (deb_q[0] ^ deb_q[1]) begin
                    step_d    = 1'b1;
                    up_down_d = deb_q[0];
                    timer_d   = TW'(HOLD_CYCLES);
                    state_d   = ST_HOLD;
                end
            end
            ST_HOLD, ST_REPEAT: begin
                if (opp_btn) begin
                    timer_d = '0;
                    state_d = ST_LOCK;
                end else if (!act_btn) begin
                    timer_d = '0;
                    state_d = ST_IDLE;
                end else if (timer_q <= TW'(1)) begin
                    step_d  = 1'b1;
                    timer_d = TW'(REPEAT_CYCLES);
                    state_d = ST_REPEAT;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_LOCK: begin
                if (!deb_q[0] && !deb_q[1]) state_d = ST_IDLE;
            end
            default: begin
                timer_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            deb_q       <= '0;
            db_cnt_q[0] <= '0;
            db_cnt_q[1] <= '0;
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            step_q      <= 1'b0;
            up_down_q   <= 1'b1;
        end else begin
            sync1_q     <= {btn_down, btn_up};
            sync2_q     <= sync1_q;
            deb_q       <= deb_d;
            db_cnt_q[0] <= db_cnt_d[0];
            db_cnt_q[1] <= db_cnt_d[1];
            state_q     <= state_d;
            timer_q     <= timer_d;
            step_q      <= step_d;
            up_down_q   <= up_down_d;
        end
    end

    assign step    = step_q;
    assign up_down = up_down_q;
    assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_button_step_ctrl.sv
// Bench for button_step_ctrl: press tables plus hand-written lock/glitch/reset
// sequences; expected step edges are queued at stimulus time and matched on output.
module tb_button_step_ctrl;

    localparam int D = 4;
    localparam int H = 8;
    localparam int R = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic btn_up, btn_down;
    logic step, up_down, busy;

    button_step_ctrl #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .REPEAT_CYCLES(R)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .step     (step),
        .up_down  (up_down),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic up;
        logic dn;
        int   len;
        logic dir;
    } vec_t;

    typedef struct {
        int   at;
        logic dir;
    } exp_t;

    vec_t vecs [6];
    exp_t exp_q [$];

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    logic       prev_step = 1'b0;
    logic [3:0] cnt4 = 4'd0;
    logic       saw_wrap = 1'b0;
    int         e0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Steps for a clean press first sampled at edge p0 and held len cycles:
    // first step D+2 edges later, then after H, then every R, while the debounced
    // level (which lags release by the same D+1 edges) is still high.
    task automatic push_press(input int p0, input int len, input logic dir);
        int t;
        int last;
        exp_t e;
        if (len < D) return;
        last  = p0 + len + D + 1;
        e.dir = dir;
        e.at  = p0 + D + 2;
        exp_q.push_back(e);
        t = e.at + H;
        while (t <= last) begin
            e.at = t;
            exp_q.push_back(e);
            t += R;
        end
    endtask

    task automatic push_one(input int at, input logic dir);
        exp_t e;
        e.at  = at;
        e.dir = dir;
        exp_q.push_back(e);
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic up, input logic dn, input int len);
        btn_up   = up;
        btn_down = dn;
        push_press(cyc + 1, len, up);
        wait_n(len);
        btn_up   = 1'b0;
        btn_down = 1'b0;
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (step) begin
            exp_t e;
            check("no_back_to_back", prev_step, 0);
            if (exp_q.size() == 0) begin
                check("unexpected_step", cyc, -1);
            end else begin
                e = exp_q.pop_front();
                check("step_edge", cyc, e.at);
                check("step_dir", up_down, e.dir);
            end
            if (up_down) begin
                cnt4 = cnt4 + 4'd1;
            end else begin
                if (cnt4 == 4'd0) saw_wrap = 1'b1;
                cnt4 = cnt4 - 4'd1;
            end
        end else if (exp_q.size() != 0 && exp_q[0].at <= cyc) begin
            check("missing_step", cyc, exp_q[0].at);
            void'(exp_q.pop_front());
        end
        prev_step = step;
    end

    initial begin
        vecs[0] = '{up: 1'b0, dn: 1'b1, len: 3,  dir: 1'b1};
        vecs[1] = '{up: 1'b0, dn: 1'b1, len: 4,  dir: 1'b0};
        vecs[2] = '{up: 1'b1, dn: 1'b0, len: 8,  dir: 1'b1};
        vecs[3] = '{up: 1'b1, dn: 1'b0, len: 9,  dir: 1'b1};
        vecs[4] = '{up: 1'b0, dn: 1'b1, len: 12, dir: 1'b0};
        vecs[5] = '{up: 1'b1, dn: 1'b0, len: 2,  dir: 1'b0};

        rst_n = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
        wait_n(3);
        check("rst_step", step, 0);
        check("rst_up_down", up_down, 1);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        wait_n(2);

        // clean up press held 30 cycles, busy rises with the first step
        btn_up = 1'b1;
        e0 = cyc + 1;
        push_press(e0, 30, 1'b1);
        wait_n(6);
        check("busy_before_first_step", busy, 0);
        wait_n(1);
        check("busy_at_first_step", busy, 1);
        wait_n(23);
        btn_up = 1'b0;
        wait_n(D + 12);
        check("hold30_idle_busy", busy, 0);
        check("hold30_dir", up_down, 1);

        for (int i = 0; i < 6; i++) begin
            press(vecs[i].up, vecs[i].dn, vecs[i].len);
            wait_n(D + 12);
            check($sformatf("vec%0d_busy", i), busy, 0);
            check($sformatf("vec%0d_dir", i), up_down, vecs[i].dir);
        end

        // simultaneous press locks out
        btn_up = 1'b1; btn_down = 1'b1;
        wait_n(20);
        check("lock_busy", busy, 1);
        btn_up = 1'b0;
        wait_n(20);
        check("lock_one_released_busy", busy, 1);
        btn_down = 1'b0;
        wait_n(D + 12);
        check("lock_release_busy", busy, 0);
        check("lock_dir_kept", up_down, 0);

        // opposite button during REPEAT
        btn_up = 1'b1;
        e0 = cyc + 1;
        push_one(e0 + D + 2, 1'b1);
        push_one(e0 + D + 2 + H, 1'b1);
        push_one(e0 + D + 2 + H + R, 1'b1);
        push_one(e0 + D + 2 + H + 2 * R, 1'b1);
        wait_n(16);
        btn_down = 1'b1;
        wait_n(12);
        btn_up = 1'b0;
        wait_n(20);
        check("repeat_lock_busy", busy, 1);
        btn_down = 1'b0;
        wait_n(D + 12);
        check("repeat_lock_idle", busy, 0);
        press(1'b1, 1'b0, 5);
        wait_n(D + 12);

        // down glitches never accepted, then a stable press
        for (int k = 0; k < 5; k++) begin
            btn_down = 1'b1;
            wait_n(3);
            btn_down = 1'b0;
            wait_n(1);
        end
        check("glitch_dir", up_down, 1);
        press(1'b0, 1'b1, 6);
        wait_n(D + 12);
        check("glitch_final_dir", up_down, 0);

        // reset during HOLD aborts, held button is a fresh press after release
        btn_down = 1'b1;
        e0 = cyc + 1;
        push_one(e0 + D + 2, 1'b0);
        wait_n(10);
        check("pre_reset_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("reset_step", step, 0);
        check("reset_busy", busy, 0);
        check("reset_up_down", up_down, 1);
        btn_down = 1'b0;
        btn_up   = 1'b1;
        wait_n(3);
        rst_n = 1'b1;
        push_press(cyc + 1, 12, 1'b1);
        wait_n(12);
        btn_up = 1'b0;
        wait_n(D + 12);
        check("post_reset_idle", busy, 0);

        // 20 down steps into a 4-bit counter from zero
        rst_n = 1'b0;
        wait_n(1);
        rst_n = 1'b1;
        cnt4 = 4'd0;
        saw_wrap = 1'b0;
        press(1'b0, 1'b1, 64);
        wait_n(D + 12);
        check("counter_final", cnt4, 12);
        check("counter_wrapped", saw_wrap, 1);

        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
